// File: rtl/clk_divider_multi.sv
// rtl/clk_divider_multi.sv - NCH glitch-free programmable clock dividers with tick strobes.
// Optional phase-alignment input enabled by defining CLKDIV_SYNC_EN.
`timescale 1ns/1ps
module clk_divider_multi #(
    parameter int NCH          = 4,
    parameter int DIV_W        = 8,
    parameter int DEFAULT_HALF = 1,
    parameter int SEL_W        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic             div_we,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [DIV_W-1:0] div_data,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick
);

    logic w_sync;
`ifdef CLKDIV_SYNC_EN
    assign w_sync = sync;
`else
    assign w_sync = 1'b0;
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [DIV_W-1:0] r_cnt;
        logic [DIV_W-1:0] r_active;
        logic [DIV_W-1:0] r_shadow;
        logic             r_clk;
        logic             r_tick;
        logic             w_wr;
        logic             w_tc;
        logic [DIV_W-1:0] w_next_active;

        // Out-of-range selects never match any channel index, so they are dropped.
        assign w_wr          = div_we && (div_sel == SEL_W'(g));
        assign w_tc          = en[g] && (r_cnt == r_active);
        assign w_next_active = w_wr ? div_data : r_shadow;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt    <= '0;
                r_active <= DIV_W'(DEFAULT_HALF);
                r_shadow <= DIV_W'(DEFAULT_HALF);
                r_clk    <= 1'b0;
                r_tick   <= 1'b0;
            end else begin
                if (w_wr) begin
                    r_shadow <= div_data;
                end
                if (w_sync) begin
                    r_cnt    <= '0;
                    r_clk    <= 1'b0;
                    r_tick   <= 1'b0;
                    r_active <= w_next_active;
                end else if (w_tc) begin
                    // Ratio changes only here, at a half-period boundary.
                    r_cnt    <= '0;
                    r_clk    <= ~r_clk;
                    r_tick   <= ~r_clk;
                    r_active <= w_next_active;
                end else begin
                    if (en[g]) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                    r_tick <= 1'b0;
                end
            end
        end

        assign clk_out[g] = r_clk;
        assign tick[g]    = r_tick;
    end

endmodule

// File: tb/tb_clk_divider_multi.sv
// tb/tb_clk_divider_multi.sv - scoreboard bench for clk_divider_multi (tick times queued per channel).
`timescale 1ns/1ps
module tb_clk_divider_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] en = 4'hF;
    logic       div_we = 1'b0;
    logic [1:0] div_sel = 2'd0;
    logic [7:0] div_data = 8'd0;
    logic [3:0] clk_out;
    logic [3:0] tick;
    logic [2:0] clk_out3;
    logic [2:0] tick3;
`ifdef CLKDIV_SYNC_EN
    logic       sync = 1'b0;
`endif

    int n_vec = 0;
    int n_err = 0;
    int cyc_abs = 0;
    int base = 0;
    logic [3:0] watch = 4'h0;
    int exp_q [4][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_abs <= cyc_abs + 1;

    clk_divider_multi u_dut (
        .clk(clk), .rst(rst), .en(en), .div_we(div_we), .div_sel(div_sel), .div_data(div_data),
`ifdef CLKDIV_SYNC_EN
        .sync(sync),
`endif
        .clk_out(clk_out), .tick(tick)
    );

    // Three-channel instance: div_sel=3 is out of range and must be ignored.
    clk_divider_multi #(.NCH(3)) u_dut3 (
        .clk(clk), .rst(rst), .en(en[2:0]), .div_we(div_we), .div_sel(div_sel), .div_data(div_data),
`ifdef CLKDIV_SYNC_EN
        .sync(sync),
`endif
        .clk_out(clk_out3), .tick(tick3)
    );

    initial begin : monitor
        int e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < 4; i++) begin
                    if (watch[i] && tick[i]) begin
                        n_vec++;
                        if (exp_q[i].size() == 0) begin
                            n_err++;
                            $display("FAIL tick_ch%0d: unexpected tick at cycle %0d, none required", i, cyc_abs - base);
                        end else begin
                            e = exp_q[i].pop_front();
                            if (e != cyc_abs - base) begin
                                n_err++;
                                $display("FAIL tick_ch%0d: tick at cycle %0d, required cycle %0d", i, cyc_abs - base, e);
                            end
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h at cycle %0d", name, act, exp, cyc_abs - base);
        end
    endtask

    task automatic wait_to(input int k);
        while (cyc_abs - base < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 4'hF;
        div_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        base = cyc_abs;
    endtask

    task automatic push_seq(input int ch, input int first, input int last, input int step);
        for (int k = first; k <= last; k += step) exp_q[ch].push_back(k);
    endtask

    task automatic end_phase(input int k);
        wait_to(k);
        @(negedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (watch[i]) begin
                n_vec++;
                if (exp_q[i].size() != 0) begin
                    n_err++;
                    $display("FAIL missing_tick_ch%0d: no tick by cycle %0d, required at cycle %0d", i, k, exp_q[i][0]);
                end
                exp_q[i].delete();
            end
        end
        watch = 4'h0;
    endtask

    task automatic write(input logic [1:0] sel, input logic [7:0] data);
        div_we = 1'b1;
        div_sel = sel;
        div_data = data;
    endtask

    initial begin
        #1;
        chk("reset_clk_out", clk_out, 4'h0);
        chk("reset_tick", tick, 4'h0);

        // Reset defaults: H=1 on all channels, period 4
        do_reset();
        for (int i = 0; i < 4; i++) push_seq(i, 2, 14, 4);
        watch = 4'hF;
        wait_to(2);  chk("dflt_rise", clk_out, 4'hF);
        wait_to(3);  chk("dflt_tick_width", tick, 4'h0);
                     chk("dflt_high", clk_out, 4'hF);
        wait_to(4);  chk("dflt_fall", clk_out, 4'h0);
        end_phase(16);

        // ch2 reprogrammed to H=4 mid-period
        do_reset();
        push_seq(2, 2, 2, 1);
        push_seq(2, 9, 29, 10);
        push_seq(0, 2, 30, 4);
        watch = 4'b0101;
        wait_to(2);  write(2'd2, 8'd4);
        wait_to(3);  div_we = 1'b0;
        wait_to(6);  chk("ch2_low_new", clk_out[2], 1'b0);
                     chk("ch1_unaffected", clk_out[1], 1'b1);
        wait_to(9);  chk("ch2_rise", clk_out[2], 1'b1);
        wait_to(13); chk("ch2_high", clk_out[2], 1'b1);
        wait_to(14); chk("ch2_fall", clk_out[2], 1'b0);
        end_phase(30);

        // H=0 on ch0 (clk/2), H=255 on ch1 (period 512, bypass on TC)
        do_reset();
        write(2'd0, 8'd0);
        wait_to(1);  write(2'd1, 8'd255);
        wait_to(2);  div_we = 1'b0;
        push_seq(0, 2, 1030, 2);
        push_seq(1, 2, 1026, 512);
        watch = 4'b0011;
        wait_to(3);   chk("ch0_h0_low", clk_out[0], 1'b0);
        wait_to(4);   chk("ch0_h0_high", clk_out[0], 1'b1);
        wait_to(257); chk("ch1_max_high", clk_out[1], 1'b1);
        wait_to(258); chk("ch1_max_fall", clk_out[1], 1'b0);
        wait_to(513); chk("ch1_max_low", clk_out[1], 1'b0);
        wait_to(514); chk("ch1_max_rise", clk_out[1], 1'b1);
        end_phase(1030);

        // Write on ch3 TC cycle (bypass); out-of-range select on the 3-channel instance
        do_reset();
        push_seq(3, 2, 2, 1);
        push_seq(3, 7, 19, 6);
        watch = 4'b1000;
        wait_to(3);  write(2'd3, 8'd2);
        wait_to(4);  div_we = 1'b0;
        wait_to(6);  chk("ch3_bypass_low", clk_out[3], 1'b0);
        wait_to(7);  chk("ch3_bypass_rise", clk_out[3], 1'b1);
                     chk("sel_oob_high", clk_out3, 3'b111);
        wait_to(8);  chk("sel_oob_low", clk_out3, 3'b000);
        wait_to(10); chk("ch3_fall", clk_out[3], 1'b0);
        end_phase(20);

        // Enable drop on ch1 for 7 cycles, then async reset mid-period
        do_reset();
        push_seq(1, 2, 2, 1);
        push_seq(1, 13, 13, 1);
        watch = 4'b0010;
        wait_to(5);  en = 4'b1101;
        wait_to(6);  chk("en_off_tick", tick[1], 1'b0);
        wait_to(9);  chk("en_off_hold", clk_out[1], 1'b0);
        wait_to(12); chk("en_off_hold_end", clk_out[1], 1'b0);
                     en = 4'hF;
        wait_to(13); chk("en_resume_rise", clk_out[1], 1'b1);
        end_phase(14);
        rst = 1'b1;
        #1;
        chk("async_rst_clk_out", clk_out, 4'h0);
        chk("async_rst_tick", tick, 4'h0);

`ifdef CLKDIV_SYNC_EN
        // H=1,2,3 on ch0..2, then sync pulse
        do_reset();
        write(2'd0, 8'd1);
        wait_to(1);  write(2'd1, 8'd2);
        wait_to(2);  write(2'd2, 8'd3);
        wait_to(3);  div_we = 1'b0;
        wait_to(19); sync = 1'b1;
        wait_to(20); sync = 1'b0;
                     chk("sync_zero", clk_out[2:0], 3'b000);
        wait_to(21); chk("sync_hold", clk_out[2:0], 3'b000);
        wait_to(22); chk("sync_ch0", clk_out[2:0], 3'b001);
                     chk("sync_tick0", tick[2:0], 3'b001);
        wait_to(23); chk("sync_ch1", clk_out[2:0], 3'b011);
        wait_to(24); chk("sync_ch2", clk_out[2:0], 3'b110);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
